// File: rtl/rca_pwr_ctrl_if.sv
// Power-sequencing signal bundle between the always-on controller (master)
// and the gated 16-bit adder domain / its power switch (slave).
interface rca_pwr_ctrl_if;
    logic       sleep_req;
    logic       wake_req;
    logic       pwr_ack;
    logic       iso_en;
    logic       ret_en;
    logic       pse;
    logic [2:0] state;
    logic       domain_on;
    logic       busy;
    logic       err;

    modport master (
        input  sleep_req, wake_req, pwr_ack,
        output iso_en, ret_en, pse, state, domain_on, busy, err
    );

    modport slave (
        output sleep_req, wake_req, pwr_ack,
        input  iso_en, ret_en, pse, state, domain_on, busy, err
    );
endinterface

// File: rtl/rca_pwr_ctrl.sv
// Power-down/power-up sequencer for the gated ripple-carry adder domain.
// Optional pwr_ack timeout with sticky err: define RCA_PWR_ACK_TIMEOUT_EN.
module rca_pwr_ctrl #(
    parameter int unsigned ISO_DLY     = 2,
    parameter int unsigned RET_DLY     = 4,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 8
) (
    input  logic           clk,
    input  logic           rst,
    rca_pwr_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_ON      = 3'd0,
        S_ISO     = 3'd1,
        S_SAVE    = 3'd2,
        S_PSW_OFF = 3'd3,
        S_OFF     = 3'd4,
        S_PSW_ON  = 3'd5,
        S_RESTORE = 3'd6,
        S_UNISO   = 3'd7
    } state_e;

    localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_DLY - 1);
    localparam logic [CNT_W-1:0] RET_LAST = CNT_W'(RET_DLY - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             iso_en_q, ret_en_q, pse_q, domain_on_q, busy_q;
    logic             ack_expired_s;
    logic [CNT_W-1:0] ack_cnt_inc_s;

    // {iso_en, ret_en, pse} for each state; pse=0 only where iso and ret are both held
    function automatic logic [2:0] drive_of(input state_e s);
        logic [2:0] d;
        case (s)
            S_ON:      d = 3'b001;
            S_ISO:     d = 3'b101;
            S_SAVE:    d = 3'b111;
            S_PSW_OFF: d = 3'b110;
            S_OFF:     d = 3'b110;
            S_PSW_ON:  d = 3'b111;
            S_RESTORE: d = 3'b101;
            S_UNISO:   d = 3'b101;
            default:   d = 3'b110;
        endcase
        return d;
    endfunction

`ifdef RCA_PWR_ACK_TIMEOUT_EN
    assign ack_expired_s = (cnt_q == ACK_LAST);
`else
    assign ack_expired_s = 1'b0;
`endif
    // Ack wait time saturates so the counter never wraps while waiting indefinitely.
    assign ack_cnt_inc_s = (cnt_q == ACK_LAST) ? cnt_q : cnt_q + CNT_ONE;

    // Next-state, dwell counter and sticky timeout flag.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        err_d   = err_q;
        case (state_q)
            S_ON: begin
                if (bus.sleep_req) state_d = S_ISO;
                else               state_d = S_ON;
            end
            S_ISO: begin
                if (cnt_q == ISO_LAST) state_d = S_SAVE;
                else                   cnt_d   = cnt_q + CNT_ONE;
            end
            S_SAVE: begin
                if (cnt_q == RET_LAST) state_d = S_PSW_OFF;
                else                   cnt_d   = cnt_q + CNT_ONE;
            end
            S_PSW_OFF: begin
                if (!bus.pwr_ack) begin
                    state_d = S_OFF;
                end else if (ack_expired_s) begin
                    state_d = S_OFF;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = ack_cnt_inc_s;
                end
            end
            S_OFF: begin
                if (bus.wake_req) state_d = S_PSW_ON;
                else              state_d = S_OFF;
            end
            S_PSW_ON: begin
                if (bus.pwr_ack) begin
                    state_d = S_RESTORE;
                end else if (ack_expired_s) begin
                    state_d = S_RESTORE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = ack_cnt_inc_s;
                end
            end
            S_RESTORE: begin
                if (cnt_q == RET_LAST) state_d = S_UNISO;
                else                   cnt_d   = cnt_q + CNT_ONE;
            end
            S_UNISO: begin
                if (cnt_q == ISO_LAST) state_d = S_ON;
                else                   cnt_d   = cnt_q + CNT_ONE;
            end
            default: begin
                state_d = S_ON;
            end
        endcase
    end

    // State register with outputs decoded from the next state so they align with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                        <= S_ON;
            cnt_q                          <= '0;
            err_q                          <= 1'b0;
            {iso_en_q, ret_en_q, pse_q}    <= drive_of(S_ON);
            domain_on_q                    <= 1'b1;
            busy_q                         <= 1'b0;
        end else begin
            state_q                        <= state_d;
            cnt_q                          <= cnt_d;
            err_q                          <= err_d;
            {iso_en_q, ret_en_q, pse_q}    <= drive_of(state_d);
            domain_on_q                    <= (state_d == S_ON);
            busy_q                         <= (state_d != S_ON) && (state_d != S_OFF);
        end
    end

    assign bus.iso_en    = iso_en_q;
    assign bus.ret_en    = ret_en_q;
    assign bus.pse       = pse_q;
    assign bus.state     = state_q;
    assign bus.domain_on = domain_on_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_rca_pwr_ctrl.sv
// Directed bench for rca_pwr_ctrl: a phase/elapsed-time model checked every cycle
// plus literal checkpoints along the power-down / power-up timeline.
module tb_rca_pwr_ctrl;
    localparam int ISO = 2;
    localparam int RET = 4;
    localparam int ACK = 64;
`ifdef RCA_PWR_ACK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    rca_pwr_ctrl_if bus ();

    rca_pwr_ctrl #(
        .ISO_DLY(ISO), .RET_DLY(RET), .ACK_TIMEOUT(ACK), .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: which phase of the sequence we are in and cycles elapsed in it.
    localparam int P_ON = 0, P_DOWN = 1, P_OFF = 2, P_UPW = 3, P_UP = 4;
    int m_phase = P_ON;
    int m_t     = 0;
    bit m_err   = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= P_ON;
            m_t     <= 0;
            m_err   <= 1'b0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            case (m_phase)
                P_ON: if (bus.sleep_req) begin m_phase <= P_DOWN; m_t <= 0; end
                P_DOWN: begin
                    if (m_t < ISO + RET) m_t <= m_t + 1;
                    else if (!bus.pwr_ack) m_phase <= P_OFF;
                    else if (TO_EN && (m_t - (ISO + RET)) == ACK - 1) begin
                        m_phase <= P_OFF; m_err <= 1'b1;
                    end else m_t <= m_t + 1;
                end
                P_OFF: if (bus.wake_req) begin m_phase <= P_UPW; m_t <= 0; end
                P_UPW: begin
                    if (bus.pwr_ack) begin m_phase <= P_UP; m_t <= 0; end
                    else if (TO_EN && m_t == ACK - 1) begin
                        m_phase <= P_UP; m_t <= 0; m_err <= 1'b1;
                    end else m_t <= m_t + 1;
                end
                P_UP: begin
                    if (m_t == RET + ISO - 1) m_phase <= P_ON;
                    else m_t <= m_t + 1;
                end
                default: m_phase <= P_ON;
            endcase
        end
    end

    function automatic int exp_state();
        case (m_phase)
            P_ON:    return 0;
            P_DOWN:  return (m_t < ISO) ? 1 : (m_t < ISO + RET) ? 2 : 3;
            P_OFF:   return 4;
            P_UPW:   return 5;
            P_UP:    return (m_t < RET) ? 6 : 7;
            default: return 0;
        endcase
    endfunction

    // {iso_en, ret_en, pse} per state, straight from the output table.
    localparam logic [2:0] DRV [8] = '{3'b001, 3'b101, 3'b111, 3'b110,
                                       3'b110, 3'b111, 3'b101, 3'b101};

    // Per-cycle compare against the model, plus the isolation/retention invariant.
    always @(negedge clk) begin
        if (m_valid) begin
            int es;
            logic [8:0] exp_v, act_v;
            es    = exp_state();
            exp_v = {es[2:0], DRV[es], (es == 0), (es != 0 && es != 4), m_err};
            act_v = {bus.state, bus.iso_en, bus.ret_en, bus.pse, bus.domain_on, bus.busy, bus.err};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL model cyc=%0d {state,iso,ret,pse,on,busy,err} act=%b req=%b",
                         cyc, act_v, exp_v);
            end
            n_cmp++;
            if ((!bus.pse && !(bus.iso_en && bus.ret_en)) || (bus.ret_en && !bus.iso_en)) begin
                n_err++;
                $display("FAIL invariant cyc=%0d act iso/ret/pse=%b%b%b req pse=0->iso=ret=1, ret=1->iso=1",
                         cyc, bus.iso_en, bus.ret_en, bus.pse);
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d act=%0d req=%0d", name, cyc, act, req);
        end
    endtask

    task automatic wait_edge(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != n) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_edge act=%0d req=%0d", cyc, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d act=running req=finished", cyc);
        $fatal(1);
    end

    initial begin
        bus.sleep_req = 1'b0;
        bus.wake_req  = 1'b0;
        bus.pwr_ack   = 1'b1;
        wait_edge(2);
        rst = 1'b0;
        chk("rst_state", {1'b0, bus.state}, 4'd0);
        chk("rst_drv", {1'b0, bus.iso_en, bus.ret_en, bus.pse}, 4'b0001);
        chk("rst_err", {3'b000, bus.err}, 4'd0);

        // Power-down: sleep sampled at edge 10, ack falls at edge 20
        wait_edge(9);  bus.sleep_req = 1'b1;
        wait_edge(10); bus.sleep_req = 1'b0;
        chk("dn_iso", {2'b00, bus.iso_en, bus.busy}, 4'b0011);
        wait_edge(11); chk("dn_ret_lo", {3'b000, bus.ret_en}, 4'd0);
        wait_edge(12); chk("dn_ret_hi", {3'b000, bus.ret_en}, 4'd1);
        wait_edge(15); chk("dn_pse_hi", {3'b000, bus.pse}, 4'd1);
        wait_edge(16); chk("dn_pse_lo", {3'b000, bus.pse}, 4'd0);
        wait_edge(19); bus.pwr_ack = 1'b0;
        chk("dn_wait", {1'b0, bus.state}, 4'd3);
        wait_edge(20); chk("dn_off", {1'b0, bus.state}, 4'd4);

        // Power-up: wake at edge 30, ack rises at edge 33
        wait_edge(29); bus.wake_req = 1'b1;
        wait_edge(30); bus.wake_req = 1'b0;
        chk("up_pse", {1'b0, bus.state}, 4'd5);
        chk("up_pse_on", {3'b000, bus.pse}, 4'd1);
        wait_edge(32); bus.pwr_ack = 1'b1;
        wait_edge(33); chk("up_ret_lo", {1'b0, bus.iso_en, bus.ret_en, bus.pse}, 4'b0101);
        wait_edge(38); chk("up_iso_hi", {3'b000, bus.iso_en}, 4'd1);
        wait_edge(39); chk("up_on", {2'b00, bus.iso_en, bus.domain_on}, 4'b0001);

        // Reset while in SAVE
        bus.sleep_req = 1'b1;
        wait_edge(40); bus.sleep_req = 1'b0;
        wait_edge(42); chk("mid_save", {1'b0, bus.state}, 4'd2);
        rst = 1'b1;
        wait_edge(43); rst = 1'b0;
        chk("mid_rst_state", {1'b0, bus.state}, 4'd0);
        chk("mid_rst_drv", {bus.err, bus.iso_en, bus.ret_en, bus.pse}, 4'b0001);

        // Filtering: both requests in OFF, sleep toggling during wake, sleep held into ON
        wait_edge(44); bus.sleep_req = 1'b1;
        wait_edge(45); bus.sleep_req = 1'b0;
        wait_edge(51); bus.pwr_ack = 1'b0;
        wait_edge(52); chk("f_off", {1'b0, bus.state}, 4'd4);
        wait_edge(54); bus.sleep_req = 1'b1; bus.wake_req = 1'b1;
        wait_edge(55); chk("f_both", {1'b0, bus.state}, 4'd5);
        bus.wake_req = 1'b0; bus.sleep_req = 1'b0;
        wait_edge(56); bus.sleep_req = 1'b1; bus.pwr_ack = 1'b1;
        wait_edge(57); chk("f_restore", {1'b0, bus.state}, 4'd6);
        bus.sleep_req = 1'b0;
        wait_edge(58); bus.sleep_req = 1'b1;
        wait_edge(63); chk("f_on", {1'b0, bus.state}, 4'd0);
        wait_edge(64); chk("f_resleep", {1'b0, bus.state}, 4'd1);
        bus.sleep_req = 1'b0; bus.pwr_ack = 1'b0;
        wait_edge(71); chk("f_off2", {1'b0, bus.state}, 4'd4);

        // Wake, then power down with pwr_ack stuck at 1
        bus.wake_req = 1'b1;
        wait_edge(72); bus.wake_req = 1'b0; bus.pwr_ack = 1'b1;
        wait_edge(79); chk("s_on", {1'b0, bus.state}, 4'd0);
        bus.sleep_req = 1'b1;
        wait_edge(80); bus.sleep_req = 1'b0;
`ifdef RCA_PWR_ACK_TIMEOUT_EN
        wait_edge(149); chk("to_wait", {bus.err, bus.state}, 4'b0011);
        wait_edge(150); chk("to_fire", {bus.err, bus.state}, 4'b1100);
        bus.wake_req = 1'b1;
        wait_edge(151); bus.wake_req = 1'b0;
        wait_edge(158); chk("to_sticky", {bus.err, bus.state}, 4'b1000);
        rst = 1'b1;
        wait_edge(159); rst = 1'b0;
        chk("to_clear", {3'b000, bus.err}, 4'd0);
`else
        wait_edge(286); chk("hold_wait", {bus.err, bus.state}, 4'b0011);
        bus.pwr_ack = 1'b0;
        wait_edge(287); chk("hold_off", {bus.err, bus.state}, 4'b0100);
`endif
        wait_edge(cyc + 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rca_pwr_ctrl.md
# rca_pwr_ctrl

Power-sequencing controller that drives the `iso_en`, `ret_en` and `pse` inputs of the power-gated 16-bit ripple-carry adder domain. A Moore FSM walks an ordered power-down sequence on `sleep_req`: isolate, save state, switch off. It walks the mirror power-up sequence on `wake_req`: switch on, restore state, de-isolate. The controller sits in the always-on domain, next to the gated adder.

## Interface
- `ISO_DLY`, 2: cycles spent in ISO and UNISO (≥1)
- `RET_DLY`, 4: cycles spent in SAVE and RESTORE (≥1)
- `ACK_TIMEOUT`, 64: max cycles waiting on `pwr_ack` (used only with the macro)
- `CNT_W`, 8: dwell/timeout counter width; must hold max(ISO_DLY, RET_DLY, ACK_TIMEOUT)

- `clk` in 1: clock
- `rst` in 1: **synchronous, active-high** reset
- `sleep_req` in 1: level request to power down; sampled only in ON
- `wake_req` in 1: level request to power up; sampled only in OFF
- `pwr_ack` in 1: power-switch status from the gated domain; 1 = rail good, 0 = rail off
- `iso_en` out 1: 1 = clamp adder outputs
- `ret_en` out 1: 1 = retention save/hold
- `pse` out 1: 1 = power switch closed (domain powered)
- `state` out 3: current FSM state encoding
- `domain_on` out 1: 1 only in ON
- `busy` out 1: 1 in every state except ON and OFF
- `err` out 1: sticky `pwr_ack` timeout flag

## Operation
- State encodings and outputs (`iso_en`/`ret_en`/`pse`):
  - ON=0: 0/0/1
  - ISO=1: 1/0/1
  - SAVE=2: 1/1/1
  - PSW_OFF=3: 1/1/0
  - OFF=4: 1/1/0
  - PSW_ON=5: 1/1/1
  - RESTORE=6: 1/0/1
  - UNISO=7: 1/0/1
- Transitions:
  - ON → ISO when `sleep_req`=1.
  - ISO → SAVE after ISO_DLY cycles.
  - SAVE → PSW_OFF after RET_DLY cycles.
  - PSW_OFF → OFF when `pwr_ack`=0 is sampled.
  - OFF → PSW_ON when `wake_req`=1.
  - PSW_ON → RESTORE when `pwr_ack`=1 is sampled.
  - RESTORE → UNISO after RET_DLY cycles.
  - UNISO → ON after ISO_DLY cycles.
- Dwell counter: loaded with 0 on state entry, incremented each cycle. The state exits on the edge where the counter equals DLY−1, so each timed state lasts exactly DLY cycles.
- Simultaneous requests: in ON only `sleep_req` matters; in OFF only `wake_req` matters. Both requests are ignored in transient states; a started sequence always runs to completion, with no abort.
- Requests are level-sensitive. If `sleep_req` is still 1 on re-entering ON, the next cycle starts a new power-down.
- Safety invariant: `pse`=0 implies `iso_en`=1 and `ret_en`=1. `iso_en` is never 0 while `ret_en`=1.
- All outputs are registered, decoded from the state register. No combinational path from any input to any output.

## Timing
- Reset (any time, including mid-sequence): next edge gives state=ON, `iso_en`=0, `ret_en`=0, `pse`=1, `domain_on`=1, `busy`=0, `err`=0, counter=0.
- `sleep_req` sampled 1 at edge k in ON: `iso_en`=1 and `busy`=1 after edge k.
  - `ret_en`=1 after edge k+ISO_DLY.
  - `pse`=0 after edge k+ISO_DLY+RET_DLY.
- Minimum power-down latency, request edge to OFF: ISO_DLY+RET_DLY+1 cycles (`pwr_ack` already 0).
- `wake_req` sampled 1 at edge m in OFF: `pse`=1 after edge m.
  - With `pwr_ack`=1 sampled at edge m+a: `ret_en`=0 after edge m+a.
  - `iso_en`=0 and `domain_on`=1 after edge m+a+RET_DLY+ISO_DLY.

## Configuration
- `RCA_PWR_ACK_TIMEOUT_EN` defined: in PSW_OFF and PSW_ON the dwell counter also counts `pwr_ack` wait cycles. If the required ack level is not seen within ACK_TIMEOUT cycles, the FSM still advances to the next state, and `err` is set and stays 1 until `rst`.
- Not defined: PSW_OFF and PSW_ON wait indefinitely for `pwr_ack`. `err` is tied to 0.

## Test plan
- Reset mid-sequence: assert `rst` while in SAVE → next cycle `state`=0, outputs 0/0/1, `err`=0.
- Power-down (ISO_DLY=2, RET_DLY=4): pulse `sleep_req` at edge 10 in ON, `pwr_ack` falls at edge 20 → `iso_en`↑ after edge 10, `ret_en`↑ after edge 12, `pse`↓ after edge 16, `state`=4 after edge 20. Check the invariant every cycle.
- Power-up: from OFF, `wake_req` at edge 30, `pwr_ack` rises at edge 33 → `pse`↑ after 30, `ret_en`↓ after 33, `iso_en`↓ and `domain_on`=1 after 39.
- Request filtering: in OFF assert `sleep_req` and `wake_req` together → only power-up runs. Toggling `sleep_req` during PSW_ON or RESTORE has no effect. Holding `sleep_req`=1 throughout → a new power-down starts on the first cycle in ON.
- Ack timeout, macro defined (ACK_TIMEOUT=64): hold `pwr_ack`=1 in PSW_OFF → `state`=4 and `err`=1 after 64 cycles. `err` persists through a full wake cycle and clears only on `rst`.
- Ack wait, macro undefined: hold `pwr_ack`=1 in PSW_OFF for 200 cycles → FSM remains in PSW_OFF, `err`=0.
